// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge
// Adapts the 8-bit CPU/ULA byte bus to a 16-bit port of the dual-port SDRAM
// controller, which uses a toggle-style req/ack handshake. Writes are posted:
// the CPU gets cpu_ready one cycle after accept while the bridge waits for
// the controller's ack. Only one request is outstanding at a time.
//
// Optional feature macro: SDRAM_CPU_BRIDGE_CACHE_EN
//   Adds a one-word (valid/tag/data) read cache. Read hits complete one cycle
//   after accept without touching SDRAM. Writes that hit the tag update the
//   cached byte and still go to SDRAM.
//
// Ports:
//   clk        SDRAM clock (shared with the controller)
//   init_n     asynchronous active-low reset
//   cpu_req    one-cycle access strobe, ignored while cpu_busy=1
//   cpu_we     1=write, 0=read
//   cpu_a      24-bit byte address
//   cpu_d      write byte
//   cpu_q      read byte, held until the next read completes
//   cpu_ready  one-cycle completion pulse
//   cpu_busy   request outstanding
//   mem_req    toggle request to the controller
//   mem_ack    controller ack; request done when mem_ack == mem_req
//   mem_we     write enable to the controller
//   mem_a      23-bit word address
//   mem_ds     byte enables {upper, lower}
//   mem_d      16-bit write data (byte replicated on both lanes)
//   mem_q      16-bit read data, valid in the ack cycle of a read
module sdram_cpu_bridge (
  input  logic        clk,
  input  logic        init_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        mem_we,
  output logic [22:0] mem_a,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_d,
  input  logic [15:0] mem_q
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WADDR_W = 23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 mem_req_nxt, mem_we_nxt;
  logic [WADDR_W-1:0]   mem_a_nxt;
  logic [1:0]           mem_ds_nxt;
  logic [WORD_W-1:0]    mem_d_nxt;
  logic [BYTE_W-1:0]    cpu_q_nxt;
  logic                 cpu_ready_nxt, cpu_busy_nxt;

  logic                 mem_done;
  logic                 rd_hit;
  logic [BYTE_W-1:0]    hit_byte;

  // Controller has finished the outstanding request
  assign mem_done = (mem_ack == mem_req);

`ifdef SDRAM_CPU_BRIDGE_CACHE_EN
  logic                 cache_valid, cache_valid_nxt;
  logic [WADDR_W-1:0]   cache_tag, cache_tag_nxt;
  logic [WORD_W-1:0]    cache_data, cache_data_nxt;

  assign rd_hit   = cache_valid && (cache_tag == cpu_a[23:1]);
  assign hit_byte = cpu_a[0] ? cache_data[15:8] : cache_data[7:0];

  // Cache fill on read completion, byte write-through on tag match at accept
  always_comb begin
    cache_valid_nxt = cache_valid;
    cache_tag_nxt   = cache_tag;
    cache_data_nxt  = cache_data;
    if (state == IDLE && cpu_req && cpu_we && cache_tag == cpu_a[23:1]) begin
      if (cpu_a[0]) cache_data_nxt[15:8] = cpu_d;
      else          cache_data_nxt[7:0]  = cpu_d;
    end
    if (state == RD_WAIT && mem_done) begin
      cache_valid_nxt = 1'b1;
      cache_tag_nxt   = mem_a;
      cache_data_nxt  = mem_q;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else begin
      cache_valid <= cache_valid_nxt;
      cache_tag   <= cache_tag_nxt;
      cache_data  <= cache_data_nxt;
    end
  end
`else
  assign rd_hit   = 1'b0;
  assign hit_byte = '0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_a_nxt     = mem_a;
    mem_ds_nxt    = mem_ds;
    mem_d_nxt     = mem_d;
    cpu_q_nxt     = cpu_q;
    cpu_ready_nxt = 1'b0;
    cpu_busy_nxt  = cpu_busy;

    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (!cpu_we && rd_hit) begin
            // Cache hit: answer directly, stay idle and not busy
            cpu_q_nxt     = hit_byte;
            cpu_ready_nxt = 1'b1;
          end else begin
            mem_we_nxt   = cpu_we;
            mem_a_nxt    = cpu_a[23:1];
            mem_ds_nxt   = cpu_a[0] ? 2'b10 : 2'b01;
            mem_d_nxt    = {cpu_d, cpu_d};
            mem_req_nxt  = ~mem_req;
            cpu_busy_nxt = 1'b1;
            if (cpu_we) begin
              // Posted write: release the CPU now, wait for the ack in WR_WAIT
              cpu_ready_nxt = 1'b1;
              state_nxt     = WR_WAIT;
            end else begin
              state_nxt = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        if (mem_done) begin
          cpu_q_nxt     = mem_ds[1] ? mem_q[15:8] : mem_q[7:0];
          cpu_ready_nxt = 1'b1;
          cpu_busy_nxt  = 1'b0;
          state_nxt     = IDLE;
        end
      end

      WR_WAIT: begin
        if (mem_done) begin
          cpu_busy_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end

      default: begin
        cpu_busy_nxt = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_ds    <= 2'b00;
      mem_d     <= '0;
      cpu_q     <= '0;
      cpu_ready <= 1'b0;
      cpu_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_a     <= mem_a_nxt;
      mem_ds    <= mem_ds_nxt;
      mem_d     <= mem_d_nxt;
      cpu_q     <= cpu_q_nxt;
      cpu_ready <= cpu_ready_nxt;
      cpu_busy  <= cpu_busy_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Directed testbench for sdram_cpu_bridge with a behavioural toggle-handshake
// SDRAM port model (configurable turnaround, sparse word memory).
module tb_sdram_cpu_bridge;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [23:0] cpu_a = '0;
  logic [7:0]  cpu_d = '0;
  logic [7:0]  cpu_q;
  logic        cpu_ready, cpu_busy;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        mem_we;
  logic [22:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic [15:0] mem_q = '0;

  int vectors = 0;
  int errors  = 0;

  // Controller model state
  int          turn = 3;
  logic [15:0] dflt = '0;
  logic [15:0] mem_model [int];
  logic [15:0] wword;
  int          cnt = 0;
  int          toggles = 0;
  logic        prev_req = 1'b0;

  always #5 clk = ~clk;

  sdram_cpu_bridge dut (
    .clk(clk), .init_n(init_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a),
    .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
  );

  // Ack matches mem_req 'turn' cycles after the cycle in which the toggle appears
  always @(posedge clk) begin
    #1;
    if (mem_req !== prev_req) toggles++;
    prev_req = mem_req;
    if (!init_n) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_req != mem_ack) begin
      if (cnt == turn) begin
        wword = mem_model.exists(int'(mem_a)) ? mem_model[int'(mem_a)] : dflt;
        if (mem_we) begin
          if (mem_ds[1]) wword[15:8] = mem_d[15:8];
          if (mem_ds[0]) wword[7:0]  = mem_d[7:0];
          mem_model[int'(mem_a)] = wword;
        end else begin
          mem_q = wword;
        end
        mem_ack = mem_req;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    init_n = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    init_n = 1'b1;
  endtask

  task automatic test_reset;
    init_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_ds} !== 4'b0000) begin
      errors++; $display("FAIL reset_mem_ctl: got %b expected 0000", {mem_req, mem_we, mem_ds});
    end
    vectors++;
    if ({mem_a, mem_d} !== 39'h0) begin
      errors++; $display("FAIL reset_mem_ad: got a=%h d=%h expected 0", mem_a, mem_d);
    end
    vectors++;
    if ({cpu_q, cpu_ready, cpu_busy} !== 10'h0) begin
      errors++; $display("FAIL reset_cpu: got q=%h rdy=%b busy=%b expected 0", cpu_q, cpu_ready, cpu_busy);
    end
    init_n = 1'b1;
  endtask

  // Read miss with lane select; ready expected at accept + 2 + 3
  task automatic test_read(input logic [23:0] a, input logic [1:0] exp_ds, input logic [7:0] exp_q);
    int ready_at = -1;
    int nready = 0;
    int t0;
    logic [7:0] q = '0;
    do_reset();
    turn = 3; dflt = 16'hA55A; mem_model.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = a;
    t0 = toggles;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (k == 1) begin
        vectors++;
        if (mem_a !== a[23:1]) begin errors++; $display("FAIL rd_mem_a: got %h expected %h", mem_a, a[23:1]); end
        vectors++;
        if (mem_ds !== exp_ds) begin errors++; $display("FAIL rd_mem_ds: got %b expected %b", mem_ds, exp_ds); end
        vectors++;
        if ({mem_we, cpu_busy} !== 2'b01) begin errors++; $display("FAIL rd_we_busy: got %b expected 01", {mem_we, cpu_busy}); end
      end
      if (k == 4) begin
        vectors++;
        if (mem_a !== a[23:1] || mem_ds !== exp_ds) begin
          errors++; $display("FAIL rd_hold: got a=%h ds=%b expected a=%h ds=%b", mem_a, mem_ds, a[23:1], exp_ds);
        end
      end
      if (cpu_ready) begin
        nready++;
        if (ready_at < 0) ready_at = k;
        q = cpu_q;
      end
    end
    vectors++;
    if (ready_at != 5) begin errors++; $display("FAIL rd_latency: got %0d expected 5", ready_at); end
    vectors++;
    if (nready != 1) begin errors++; $display("FAIL rd_ready_count: got %0d expected 1", nready); end
    vectors++;
    if (q !== exp_q) begin errors++; $display("FAIL rd_cpu_q: got %h expected %h", q, exp_q); end
    vectors++;
    if (toggles - t0 != 1) begin errors++; $display("FAIL rd_toggles: got %0d expected 1", toggles - t0); end
    vectors++;
    if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end: got %b expected 0", cpu_busy); end
  endtask

  task automatic test_read_miss;
    test_read(24'h000100, 2'b01, 8'h5A);
  endtask

  task automatic test_upper_lane;
    test_read(24'h000101, 2'b10, 8'hA5);
  endtask

  // Posted write, ack 4 cycles after the toggle; a request while busy is dropped
  task automatic test_posted_write;
    int nready = 0;
    int t0;
    do_reset();
    turn = 4; dflt = 16'h0000; mem_model.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 24'h001235; cpu_d = 8'h3C;
    t0 = toggles;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_ready) nready++;
      if (k == 1) begin
        cpu_req = 1'b0;
        vectors++;
        if ({cpu_ready, cpu_busy, mem_we} !== 3'b111) begin
          errors++; $display("FAIL wr_ready_busy_we: got %b expected 111", {cpu_ready, cpu_busy, mem_we});
        end
        vectors++;
        if (mem_d !== 16'h3C3C) begin errors++; $display("FAIL wr_mem_d: got %h expected 3c3c", mem_d); end
        vectors++;
        if (mem_ds !== 2'b10) begin errors++; $display("FAIL wr_mem_ds: got %b expected 10", mem_ds); end
        vectors++;
        if (mem_a !== 23'h00091A) begin errors++; $display("FAIL wr_mem_a: got %h expected 00091a", mem_a); end
      end
      if (k == 2) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h000500;
      end
      if (k == 3) cpu_req = 1'b0;
      if (k == 4) begin
        vectors++;
        if (cpu_busy !== 1'b1 || mem_d !== 16'h3C3C || mem_we !== 1'b1) begin
          errors++; $display("FAIL wr_hold: got busy=%b d=%h we=%b expected 1 3c3c 1", cpu_busy, mem_d, mem_we);
        end
      end
      if (k == 6) begin
        vectors++;
        if (cpu_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_fall: got %b expected 0", cpu_busy); end
      end
    end
    vectors++;
    if (nready != 1) begin errors++; $display("FAIL wr_ready_count: got %0d expected 1", nready); end
    vectors++;
    if (toggles - t0 != 1) begin errors++; $display("FAIL wr_busy_drop: got %0d toggles expected 1", toggles - t0); end
    vectors++;
    if (!mem_model.exists(23'h00091A) || mem_model[23'h00091A] !== 16'h3C00) begin
      errors++; $display("FAIL wr_memory: got %h expected 3c00",
                         mem_model.exists(23'h00091A) ? mem_model[23'h00091A] : 16'hxxxx);
    end
  endtask

  // Write then read of the same byte; the read may only toggle after the write ack
  task automatic test_back_to_back;
    int ack_at = -1;
    int rd_tog_at = -1;
    int t0;
    logic issued = 1'b0;
    logic got = 1'b0;
    logic [7:0] q = '0;
    do_reset();
    turn = 2; dflt = 16'hBEEF; mem_model.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 24'h002000; cpu_d = 8'h77;
    t0 = toggles;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (ack_at < 0 && toggles - t0 == 1 && mem_ack === mem_req) ack_at = k;
      if (rd_tog_at < 0 && toggles - t0 == 2) rd_tog_at = k;
      if (issued && cpu_ready && !got) begin got = 1'b1; q = cpu_q; end
      if (!issued && !cpu_busy && k > 1) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h002000;
        issued = 1'b1;
      end
    end
    vectors++;
    if (ack_at != 3) begin errors++; $display("FAIL b2b_write_ack: got cycle %0d expected 3", ack_at); end
    vectors++;
    if (rd_tog_at != 5) begin errors++; $display("FAIL b2b_read_toggle: got cycle %0d expected 5", rd_tog_at); end
    vectors++;
    if (!got || q !== 8'h77) begin errors++; $display("FAIL b2b_cpu_q: got %h (done=%b) expected 77", q, got); end
  endtask

  // Reset while in RD_WAIT aborts; next read toggles mem_req from 0 to 1
  task automatic test_reset_mid_read;
    int t0;
    logic got = 1'b0;
    logic [7:0] q = '0;
    do_reset();
    turn = 10; dflt = 16'h1111; mem_model.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h000400;
    @(negedge clk);
    cpu_req = 1'b0;
    vectors++;
    if ({cpu_busy, mem_req} !== 2'b11) begin errors++; $display("FAIL rst_pre: got %b expected 11", {cpu_busy, mem_req}); end
    @(negedge clk);
    init_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_ds, cpu_ready, cpu_busy} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_ctl: got %b expected 000000", {mem_req, mem_we, mem_ds, cpu_ready, cpu_busy});
    end
    vectors++;
    if ({mem_a, mem_d, cpu_q} !== 47'h0) begin
      errors++; $display("FAIL rst_mid_data: got a=%h d=%h q=%h expected 0", mem_a, mem_d, cpu_q);
    end
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    turn = 3;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h000402;
    t0 = toggles;
    @(negedge clk);
    cpu_req = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || toggles - t0 != 1) begin
      errors++; $display("FAIL rst_next_toggle: got req=%b toggles=%0d expected 1 1", mem_req, toggles - t0);
    end
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_ready && !got) begin got = 1'b1; q = cpu_q; end
    end
    vectors++;
    if (!got || q !== 8'h11) begin errors++; $display("FAIL rst_next_read: got %h (done=%b) expected 11", q, got); end
  endtask

`ifdef SDRAM_CPU_BRIDGE_CACHE_EN
  task automatic test_cache;
    int t0;
    do_reset();
    turn = 3; dflt = 16'h1234; mem_model.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h000200;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int k = 0; k < 12 && cpu_busy; k++) @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h000201;
    t0 = toggles;
    @(negedge clk);
    cpu_req = 1'b0;
    vectors++;
    if ({cpu_ready, cpu_busy} !== 2'b10 || cpu_q !== 8'h12) begin
      errors++; $display("FAIL cache_hit: got rdy=%b busy=%b q=%h expected 1 0 12", cpu_ready, cpu_busy, cpu_q);
    end
    vectors++;
    if (toggles - t0 != 0) begin errors++; $display("FAIL cache_hit_toggle: got %0d expected 0", toggles - t0); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 24'h000200; cpu_d = 8'hFF;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int k = 0; k < 12 && cpu_busy; k++) @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 24'h000200;
    t0 = toggles;
    @(negedge clk);
    cpu_req = 1'b0;
    vectors++;
    if (cpu_ready !== 1'b1 || cpu_q !== 8'hFF || toggles - t0 != 0) begin
      errors++; $display("FAIL cache_write_through: got rdy=%b q=%h toggles=%0d expected 1 ff 0",
                         cpu_ready, cpu_q, toggles - t0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_miss();
    test_upper_lane();
    test_posted_write();
    test_back_to_back();
    test_reset_mid_read();
`ifdef SDRAM_CPU_BRIDGE_CACHE_EN
    test_cache();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
